// File: rtl/ysyx_25030081_lsu_pkg.sv
// Shared LSU definitions: decoder mem_op encodings, LSU state encodings and
// the default response watchdog limit.
package ysyx_25030081_lsu_pkg;

  localparam logic [2:0] MEM_OP_B  = 3'b000;
  localparam logic [2:0] MEM_OP_H  = 3'b001;
  localparam logic [2:0] MEM_OP_W  = 3'b010;
  localparam logic [2:0] MEM_OP_BU = 3'b100;
  localparam logic [2:0] MEM_OP_HU = 3'b101;

  localparam int MEM_OP_UNSIGNED_BIT = 2;
  localparam int MEM_OP_WORD_BIT     = 1;
  localparam int MEM_OP_HALF_BIT     = 0;

  localparam int unsigned LSU_RSP_TIMEOUT_DEFAULT = 32'd255;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_RSP  = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/ysyx_25030081_lsu_align.sv
// Combinational lane logic: store data replication / byte strobes, and load
// lane extraction with sign or zero extension.
module ysyx_25030081_lsu_align
  import ysyx_25030081_lsu_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Half accesses use only a[1], so a half at offset 3 lands on bytes 2-3.
  assign ld_byte_s = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
  assign ld_half_s = ld_rdata[{ld_addr_lo[1], 4'b0000} +: 16];

  // Store lane replication and strobe generation
  always_comb begin
    st_wdata = 32'h0000_0000;
    st_wmask = 4'b0000;
    if (st_op[MEM_OP_WORD_BIT]) begin
      st_wdata = st_data;
      st_wmask = 4'b1111;
    end else if (st_op[MEM_OP_HALF_BIT]) begin
      st_wdata = {2{st_data[15:0]}};
      st_wmask = 4'b0011 << {st_addr_lo[1], 1'b0};
    end else begin
      st_wdata = {4{st_data[7:0]}};
      st_wmask = 4'b0001 << st_addr_lo;
    end
  end

  // Load lane extraction and extension
  always_comb begin
    ld_data = 32'h0000_0000;
    if (ld_op[MEM_OP_WORD_BIT]) begin
      ld_data = ld_rdata;
    end else if (ld_op[MEM_OP_HALF_BIT]) begin
      if (ld_op[MEM_OP_UNSIGNED_BIT]) begin
        ld_data = {16'h0000, ld_half_s};
      end else begin
        ld_data = {{16{ld_half_s[15]}}, ld_half_s};
      end
    end else begin
      if (ld_op[MEM_OP_UNSIGNED_BIT]) begin
        ld_data = {24'h00_0000, ld_byte_s};
      end else begin
        ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
      end
    end
  end

endmodule

// File: rtl/ysyx_25030081_lsu.sv
// Load/store unit: one outstanding EXU request turned into a word-aligned bus
// transaction. Define YSYX_25030081_LSU_MISALIGN_CHECK_EN to reject misaligned accesses.
module ysyx_25030081_lsu
  import ysyx_25030081_lsu_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = LSU_RSP_TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_ren,
  input  logic        in_wen,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  input  logic        mem_rsp_err
);

  lsu_state_e  state_r, state_nxt_s;
  logic [1:0]  addr_lo_r;
  logic [2:0]  op_r;
  logic        wen_r;
  logic [31:0] tmo_cnt_r;
  logic        timeout_hit_s;
  logic        misalign_s;
  logic [31:0] st_wdata_s;
  logic [3:0]  st_wmask_s;
  logic [31:0] ld_data_s;

  ysyx_25030081_lsu_align u_align (
    .st_op      (in_op),
    .st_addr_lo (in_addr[1:0]),
    .st_data    (in_wdata),
    .st_wdata   (st_wdata_s),
    .st_wmask   (st_wmask_s),
    .ld_op      (op_r),
    .ld_addr_lo (addr_lo_r),
    .ld_rdata   (mem_rsp_rdata),
    .ld_data    (ld_data_s)
  );

`ifdef YSYX_25030081_LSU_MISALIGN_CHECK_EN
  assign misalign_s = (in_ren | in_wen) &
                      (in_op[MEM_OP_WORD_BIT] ? (in_addr[1:0] != 2'b00)
                                              : (in_op[MEM_OP_HALF_BIT] & in_addr[0]));
`else
  assign misalign_s = 1'b0;
`endif

  assign timeout_hit_s = (RSP_TIMEOUT != 32'd0) && (tmo_cnt_r == RSP_TIMEOUT - 32'd1);
  assign in_ready      = (state_r == LSU_IDLE);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= LSU_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LSU_IDLE: begin
        if (in_valid) begin
          if (misalign_s || !(in_ren || in_wen)) begin
            state_nxt_s = LSU_DONE;
          end else begin
            state_nxt_s = LSU_REQ;
          end
        end else begin
          state_nxt_s = LSU_IDLE;
        end
      end
      LSU_REQ: begin
        if (mem_req_ready) begin
          state_nxt_s = LSU_RSP;
        end else begin
          state_nxt_s = LSU_REQ;
        end
      end
      LSU_RSP: begin
        if (mem_rsp_valid || timeout_hit_s) begin
          state_nxt_s = LSU_DONE;
        end else begin
          state_nxt_s = LSU_RSP;
        end
      end
      LSU_DONE: begin
        if (out_ready) begin
          state_nxt_s = LSU_IDLE;
        end else begin
          state_nxt_s = LSU_DONE;
        end
      end
      default: state_nxt_s = LSU_IDLE;
    endcase
  end

  // Request latches, bus fields, watchdog and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_lo_r     <= 2'b00;
      op_r          <= 3'b000;
      wen_r         <= 1'b0;
      tmo_cnt_r     <= 32'd0;
      mem_req_valid <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= 32'h0000_0000;
      mem_req_wdata <= 32'h0000_0000;
      mem_req_wmask <= 4'b0000;
      out_valid     <= 1'b0;
      out_rdata     <= 32'h0000_0000;
      out_err       <= 1'b0;
    end else begin
      mem_req_valid <= (state_nxt_s == LSU_REQ);
      out_valid     <= (state_nxt_s == LSU_DONE);
      case (state_r)
        LSU_IDLE: begin
          if (in_valid) begin
            addr_lo_r     <= in_addr[1:0];
            op_r          <= in_op;
            wen_r         <= in_wen;
            mem_req_wen   <= in_wen;
            mem_req_addr  <= {in_addr[31:2], 2'b00};
            mem_req_wdata <= in_wen ? st_wdata_s : 32'h0000_0000;
            mem_req_wmask <= in_wen ? st_wmask_s : 4'b0000;
            out_rdata     <= 32'h0000_0000;
            out_err       <= misalign_s;
          end
        end
        LSU_REQ: begin
          if (mem_req_ready) begin
            tmo_cnt_r <= 32'd0;
          end
        end
        LSU_RSP: begin
          if (mem_rsp_valid) begin
            out_rdata <= wen_r ? 32'h0000_0000 : ld_data_s;
            out_err   <= mem_rsp_err;
          end else if (timeout_hit_s) begin
            out_rdata <= 32'h0000_0000;
            out_err   <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
          end
        end
        LSU_DONE: begin
          tmo_cnt_r <= 32'd0;
        end
        default: begin
          tmo_cnt_r <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030081_lsu.sv
// Directed self-checking bench for ysyx_25030081_lsu (watchdog set to 4 cycles).
module tb_ysyx_25030081_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_ren, in_wen;
  logic [2:0]  in_op;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  ysyx_25030081_lsu #(.RSP_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
    .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One full EXU -> bus -> WBU transaction; all expectations passed in.
  task automatic run_txn(
    input string       tag,
    input logic        ren, input logic wen, input logic [2:0] op,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic        expect_bus, input int req_stall,
    input logic [31:0] exp_addr, input logic [31:0] exp_wdata, input logic [3:0] exp_mask,
    input logic        give_rsp, input logic [31:0] rsp_rdata, input logic rsp_err,
    input int          exp_rsp_cycles, input int out_stall,
    input logic [31:0] exp_rdata, input logic exp_err);
    int cyc;
    @(negedge clock);
    check_eq({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_ren = ren; in_wen = wen; in_op = op;
    in_addr = addr; in_wdata = wdata;
    @(negedge clock);
    in_valid = 1'b0;
    if (expect_bus) begin
      for (int i = 0; i <= req_stall; i++) begin
        check_eq({tag, ".req_ctl"}, {26'd0, mem_req_valid, mem_req_wen, mem_req_wmask},
                 {26'd0, 1'b1, wen, exp_mask});
        check_eq({tag, ".req_addr"}, mem_req_addr, exp_addr);
        check_eq({tag, ".req_wdata"}, mem_req_wdata, exp_wdata);
        if (i == req_stall) mem_req_ready = 1'b1;
        @(negedge clock);
      end
      mem_req_ready = 1'b0;
      check_eq({tag, ".req_dropped"}, {31'd0, mem_req_valid}, 32'd0);
      cyc = 0;
      if (give_rsp) begin
        mem_rsp_valid = 1'b1; mem_rsp_rdata = rsp_rdata; mem_rsp_err = rsp_err;
        @(negedge clock);
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        cyc = 1;
      end else begin
        while (!out_valid && cyc < 20) begin
          @(negedge clock);
          cyc++;
        end
      end
      check_eq({tag, ".rsp_cycles"}, cyc, exp_rsp_cycles);
    end else begin
      check_eq({tag, ".no_bus"}, {31'd0, mem_req_valid}, 32'd0);
    end
    for (int i = 0; i <= out_stall; i++) begin
      check_eq({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
      check_eq({tag, ".out_rdata"}, out_rdata, exp_rdata);
      check_eq({tag, ".out_err"}, {31'd0, out_err}, {31'd0, exp_err});
      if (i == out_stall) out_ready = 1'b1;
      @(negedge clock);
    end
    out_ready = 1'b0;
    check_eq({tag, ".back_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_op = 3'b000;
    in_addr = 32'h0; in_wdata = 32'h0;
    out_ready = 1'b0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'h0; mem_rsp_err = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst.req", {mem_req_valid, mem_req_wen, mem_req_wmask} , 32'd0);
    check_eq("rst.req_addr", mem_req_addr | mem_req_wdata, 32'd0);
    check_eq("rst.out", {out_valid, out_err, in_ready}, 32'd1);
    check_eq("rst.out_rdata", out_rdata, 32'd0);
    reset = 1'b0;

    run_txn("sb", 1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB,
            1'b1, 0, 32'h8000_0000, 32'hABAB_ABAB, 4'b1000,
            1'b1, 32'hDEAD_BEEF, 1'b0, 1, 0, 32'h0, 1'b0);
    run_txn("lb", 1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'h0,
            1'b1, 0, 32'h8000_0000, 32'h0, 4'b0000,
            1'b1, 32'h1234_F0AA, 1'b0, 1, 0, 32'hFFFF_FFF0, 1'b0);
    run_txn("lbu", 1'b1, 1'b0, 3'b100, 32'h8000_0001, 32'h0,
            1'b1, 0, 32'h8000_0000, 32'h0, 4'b0000,
            1'b1, 32'h1234_F0AA, 1'b0, 1, 0, 32'h0000_00F0, 1'b0);
    run_txn("lh", 1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0,
            1'b1, 0, 32'h0000_0000, 32'h0, 4'b0000,
            1'b1, 32'h8001_0000, 1'b0, 1, 0, 32'hFFFF_8001, 1'b0);
    run_txn("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0,
            1'b1, 0, 32'h0000_0000, 32'h0, 4'b0000,
            1'b1, 32'h8001_0000, 1'b0, 1, 0, 32'h0000_8001, 1'b0);
    run_txn("lw_stall", 1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0,
            1'b1, 5, 32'h8000_0010, 32'h0, 4'b0000,
            1'b1, 32'hCAFE_F00D, 1'b0, 1, 3, 32'hCAFE_F00D, 1'b0);
    run_txn("lw_timeout", 1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0,
            1'b1, 0, 32'h8000_0020, 32'h0, 4'b0000,
            1'b0, 32'h0, 1'b0, 4, 0, 32'h0, 1'b1);
    run_txn("sw_err", 1'b0, 1'b1, 3'b010, 32'h8000_0008, 32'h1122_3344,
            1'b1, 0, 32'h8000_0008, 32'h1122_3344, 4'b1111,
            1'b1, 32'h5555_5555, 1'b1, 1, 0, 32'h0, 1'b1);
    run_txn("sh_both", 1'b1, 1'b1, 3'b001, 32'h8000_0006, 32'h0000_BEEF,
            1'b1, 0, 32'h8000_0004, 32'hBEEF_BEEF, 4'b1100,
            1'b1, 32'h7777_7777, 1'b0, 1, 0, 32'h0, 1'b0);
    run_txn("nop", 1'b0, 1'b0, 3'b010, 32'h8000_0000, 32'h0,
            1'b0, 0, 32'h0, 32'h0, 4'b0000,
            1'b0, 32'h0, 1'b0, 0, 0, 32'h0, 1'b0);
`ifdef YSYX_25030081_LSU_MISALIGN_CHECK_EN
    run_txn("lh_mis", 1'b1, 1'b0, 3'b001, 32'h8000_0003, 32'h0,
            1'b0, 0, 32'h0, 32'h0, 4'b0000,
            1'b0, 32'h0, 1'b0, 0, 0, 32'h0, 1'b1);
`else
    run_txn("lh_mis", 1'b1, 1'b0, 3'b001, 32'h8000_0003, 32'h0,
            1'b1, 0, 32'h8000_0000, 32'h0, 4'b0000,
            1'b1, 32'hBEEF_1234, 1'b0, 1, 0, 32'hFFFF_BEEF, 1'b0);
`endif

    // Reset while waiting for a response
    @(negedge clock);
    in_valid = 1'b1; in_ren = 1'b1; in_wen = 1'b0; in_op = 3'b010; in_addr = 32'h8000_0040;
    @(negedge clock);
    in_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    check_eq("rst_rsp.pre", {30'd0, in_ready, mem_req_valid}, 32'd0);
    reset = 1'b1;
    #1;
    check_eq("rst_rsp.async", {29'd0, in_ready, mem_req_valid, out_valid}, 32'd4);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_rsp.after", {29'd0, in_ready, mem_req_valid, out_valid}, 32'd4);

    run_txn("lbu_post", 1'b1, 1'b0, 3'b100, 32'h8000_0042, 32'h0,
            1'b1, 0, 32'h8000_0040, 32'h0, 4'b0000,
            1'b1, 32'h0099_0000, 1'b0, 1, 0, 32'h0000_0099, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_25030081_lsu.md
Name: ysyx_25030081_lsu

Overview:
- Load/store unit; the responder for the decoder's mem_ren/mem_wen/mem_op controls.
- Takes one memory request from EXU (address = ALU result, store data = rs2).
- Converts it to a word-aligned bus transaction with byte mask, waits for the response, and returns the sign- or zero-extended load result to WBU.
- Sits between EXU and the data-memory bus.

Parameters:
- RSP_TIMEOUT, 255: cycles allowed in RSP before aborting with error; 0 disables the watchdog.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  EXU request valid
- in_ready  out  1  LSU can accept a request
- in_ren  in  1  load (decoder mem_ren)
- in_wen  in  1  store (decoder mem_wen)
- in_op  in  3  decoder mem_op: [2] unsigned, [1] word, [0] half; 000 = byte
- in_addr  in  32  byte address
- in_wdata  in  32  store data, LSB-justified
- out_valid  out  1  result valid
- out_ready  in  1  WBU accepts result
- out_rdata  out  32  extended load data; 0 for stores
- out_err  out  1  bus error or timeout (or misalign, see feature)
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_wen  out  1  1 = write
- mem_req_addr  out  32  in_addr with [1:0] forced to 0
- mem_req_wdata  out  32  lane-replicated store data
- mem_req_wmask  out  4  byte strobes; 0000 for reads
- mem_rsp_valid  in  1  response valid; always accepted, no ready
- mem_rsp_rdata  in  32  read word
- mem_rsp_err  in  1  response error

Behaviour:
- FSM states: IDLE, REQ, RSP, DONE. Reset enters IDLE asynchronously from any state. A mid-transaction request is dropped; the bus side must be reset together.
- Reset values: mem_req_*, out_valid, out_rdata, out_err all 0. in_ready = (state==IDLE), so it is 1 after reset.
- IDLE:
  - On in_valid, latch addr[1:0], op, wen, and the formatted wdata/mask.
  - If in_wen|in_ren, go to REQ. Otherwise go to DONE with rdata=0, err=0.
  - If both wen and ren are set, the request is a store.
- Store formatting:
  - byte: wdata={4{d[7:0]}}, mask=0001<<a[1:0]
  - half: wdata={2{d[15:0]}}, mask=0011<<{a[1],0}
  - word: wdata=d, mask=1111
- REQ:
  - mem_req_valid=1; all mem_req_* fields stay stable until mem_req_ready.
  - On handshake, go to RSP and clear the timeout counter.
  - A mem_rsp_valid seen in REQ is ignored; the bus must respond at least one cycle after handshake.
- RSP:
  - On mem_rsp_valid, go to DONE and capture err=mem_rsp_err.
  - Load extract:
    - byte = rdata >> (8*a[1:0]); half = rdata >> (16*a[1])
    - Sign-extend unless op[2]=1; word is passed through.
  - Stores return rdata=0.
  - If RSP_TIMEOUT!=0 and the counter reaches RSP_TIMEOUT with no response, go to DONE with err=1, rdata=0. A late response is dropped, since mem_rsp_valid is ignored outside RSP.
- DONE:
  - out_valid=1; out_rdata and out_err stay stable until out_ready, then go to IDLE.
  - If out_ready is already high on DONE entry, the result completes that cycle.
- Latency: minimum 3 cycles from in handshake to out_valid (ready bus, 1-cycle response). No back-to-back overlap: one outstanding request.
- Without the optional feature, misaligned accesses are silently truncated:
  - half at a[1:0]=3 touches bytes 2-3
  - word ignores a[1:0]

Optional Feature:
- Macro: YSYX_25030081_LSU_MISALIGN_CHECK_EN.
- Defined:
  - In IDLE, half with a[0]=1 or word with a[1:0]!=0 skips REQ/RSP.
  - It goes straight to DONE with out_err=1, rdata=0; no bus request is issued.
- Undefined: the truncation behaviour above; out_err comes only from the bus or the timeout.

Decomposition:
- Shared header (alongside the decoder's macro file) holds:
  - mem_op field encodings (MEM_OP_B/H/W/BU/HU, unsigned bit, word bit)
  - LSU state encodings
  - the RSP_TIMEOUT default
- One combinational sub-module, ysyx_25030081_lsu_align:
  - store lane replication and wmask generation
  - load lane extraction and extension
- The FSM, latches and timeout counter stay in the top.

Test Plan:
- sb d=0x000000AB, addr=0x80000003 -> req addr 0x80000000, wmask 1000, wdata 0xABABABAB, wen=1; rsp -> out_rdata 0, err 0.
- lb addr=0x80000001, rsp rdata 0x1234F0AA -> out_rdata 0xFFFFFFF0.
- lbu with the same address and rdata -> 0x000000F0.
- lh addr=2, rsp 0x8001_0000 -> out_rdata 0xFFFF8001.
- lhu addr=2, same rsp -> out_rdata 0x00008001.
- lw with mem_req_ready held low 5 cycles -> mem_req fields stable all 5 cycles, one handshake; out_ready low 3 cycles -> out_valid/out_rdata held, then IDLE.
- RSP_TIMEOUT=4, no response -> out_err=1 after 4 RSP cycles.
- mem_rsp_err=1 on sw -> out_err=1.
- Reset asserted in RSP -> immediate IDLE, mem_req_valid=0, in_ready=1 after release.
- lh addr=0x3 with YSYX_25030081_LSU_MISALIGN_CHECK_EN -> no mem_req_valid, out_err=1.
- lh addr=0x3 without the macro -> bus read issued; rdata bytes 2-3 returned, err=0.
